// File: rtl/prach_pkt_framer.sv
// PRACH packet framer: packs four same-channel IQ samples per 128-bit beat and emits Avalon-ST packets.
// Optional build macro PRACH_FRAMER_STATS_EN enables the saturating dropped-beat counter on drop_cnt.
`timescale 1ns/1ps
module prach_pkt_framer #(
  parameter int NumChn    = 24,
  parameter int PktBeats  = 16,
  parameter int FifoDepth = 64
) (
  input  logic         clk_dsp,
  input  logic         rst_dsp,
  input  logic         sync_in,
  input  logic         din_dv,
  input  logic [4:0]   din_chn,
  input  logic [31:0]  din_dq,
  output logic         avst_source_valid,
  output logic [127:0] avst_source_data,
  output logic [15:0]  avst_source_channel,
  output logic         avst_source_startofpacket,
  output logic         avst_source_endofpacket,
  input  logic         avst_source_ready,
  output logic         ovf_sticky,
  output logic [15:0]  drop_cnt
);
  localparam int BW = (PktBeats > 1) ? $clog2(PktBeats) : 1;
  localparam int AW = $clog2(FifoDepth);
  localparam int EW = 128 + 5 + 2;
  localparam logic [5:0]    NumChnL  = 6'(NumChn);
  localparam logic [BW-1:0] LastBeat = BW'(PktBeats - 1);
  localparam logic [AW:0]   FullLvl  = (AW + 1)'(FifoDepth);

  logic [95:0]   part_q [NumChn];
  logic [1:0]    sidx_q [NumChn];
  logic [BW-1:0] bidx_q [NumChn];

  logic          in_ok;
  logic          beat_done;
  logic          last_beat;
  logic [1:0]    cur_sidx;
  logic [BW-1:0] cur_bidx;
  logic [95:0]   cur_part;

  logic          push_q;
  logic [EW-1:0] push_entry_q;

  // Sync forces the arriving sample to slot 0 / beat 0 of its channel.
  always_comb begin
    in_ok    = din_dv && ({1'b0, din_chn} < NumChnL);
    cur_sidx = 2'd0;
    cur_bidx = '0;
    cur_part = '0;
    if (in_ok) begin
      cur_sidx = sync_in ? 2'd0 : sidx_q[din_chn];
      cur_bidx = sync_in ? '0 : bidx_q[din_chn];
      cur_part = part_q[din_chn];
    end
    beat_done = in_ok && (cur_sidx == 2'd3);
    last_beat = (cur_bidx == LastBeat);
  end

  always_ff @(posedge clk_dsp or posedge rst_dsp) begin
    if (rst_dsp) begin
      for (int i = 0; i < NumChn; i++) begin
        part_q[i] <= '0;
        sidx_q[i] <= '0;
        bidx_q[i] <= '0;
      end
      push_q       <= 1'b0;
      push_entry_q <= '0;
    end else begin
      if (sync_in) begin
        for (int i = 0; i < NumChn; i++) begin
          sidx_q[i] <= '0;
          bidx_q[i] <= '0;
        end
      end
      // Same-channel update below takes precedence over the sync clear.
      if (in_ok) begin
        case (cur_sidx)
          2'd0:    part_q[din_chn][95:64] <= din_dq;
          2'd1:    part_q[din_chn][63:32] <= din_dq;
          2'd2:    part_q[din_chn][31:0]  <= din_dq;
          default: ;
        endcase
        sidx_q[din_chn] <= cur_sidx + 2'd1;
        if (beat_done)
          bidx_q[din_chn] <= last_beat ? '0 : cur_bidx + BW'(1);
      end
      push_q       <= beat_done;
      push_entry_q <= {cur_part, din_dq, din_chn, (cur_bidx == '0), last_beat};
    end
  end

  logic [EW-1:0] mem_q [FifoDepth];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          out_valid_q;
  logic [EW-1:0] out_entry_q;
  logic          ovf_q;

  logic [AW:0] occ;
  logic        full;
  logic        pop;
  logic        accept;
  logic        drop;
  logic        load_out;
  logic        from_mem;
  logic        bypass;
  logic        mem_wr;

  // Occupancy includes the show-ahead output register.
  assign occ      = cnt_q + {{AW{1'b0}}, out_valid_q};
  assign full     = (occ == FullLvl);
  assign pop      = out_valid_q & avst_source_ready;
  assign accept   = push_q & (~full | pop);
  assign drop     = push_q & full & ~pop;
  assign load_out = ~out_valid_q | pop;
  assign from_mem = load_out & (cnt_q != '0);
  assign bypass   = load_out & (cnt_q == '0) & accept;
  assign mem_wr   = accept & ~bypass;

  always_ff @(posedge clk_dsp) begin
    if (mem_wr)
      mem_q[wr_ptr_q] <= push_entry_q;
  end

  always_ff @(posedge clk_dsp or posedge rst_dsp) begin
    if (rst_dsp) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (mem_wr)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (from_mem)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({mem_wr, from_mem})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: ;
      endcase
      if (load_out) begin
        out_valid_q <= from_mem | bypass;
        if (from_mem)
          out_entry_q <= mem_q[rd_ptr_q];
        else if (bypass)
          out_entry_q <= push_entry_q;
      end
      if (drop)
        ovf_q <= 1'b1;
    end
  end

  assign avst_source_valid         = out_valid_q;
  assign avst_source_data          = out_entry_q[EW-1:7];
  assign avst_source_channel       = {11'd0, out_entry_q[6:2]};
  assign avst_source_startofpacket = out_entry_q[1];
  assign avst_source_endofpacket   = out_entry_q[0];
  assign ovf_sticky                = ovf_q;

`ifdef PRACH_FRAMER_STATS_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk_dsp or posedge rst_dsp) begin
    if (rst_dsp)
      drop_cnt_q <= '0;
    else if (drop && (drop_cnt_q != 16'hFFFF))
      drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_prach_pkt_framer.sv
// Directed self-checking bench for prach_pkt_framer: packing, interleave, backpressure, overflow, sync, reset.
`timescale 1ns/1ps
module tb_prach_pkt_framer;
  logic         clk_dsp = 1'b0;
  logic         rst_dsp = 1'b0;
  logic         sync_in = 1'b0;
  logic         din_dv = 1'b0;
  logic [4:0]   din_chn = 5'd0;
  logic [31:0]  din_dq = 32'd0;
  logic         avst_source_ready = 1'b0;
  logic         avst_source_valid;
  logic [127:0] avst_source_data;
  logic [15:0]  avst_source_channel;
  logic         avst_source_startofpacket;
  logic         avst_source_endofpacket;
  logic         ovf_sticky;
  logic [15:0]  drop_cnt;

  int checks = 0;
  int failures = 0;

  logic [127:0] cap_data [$];
  logic [15:0]  cap_chn [$];
  logic         cap_sop [$];
  logic         cap_eop [$];

  prach_pkt_framer dut (
    .clk_dsp                   (clk_dsp),
    .rst_dsp                   (rst_dsp),
    .sync_in                   (sync_in),
    .din_dv                    (din_dv),
    .din_chn                   (din_chn),
    .din_dq                    (din_dq),
    .avst_source_valid         (avst_source_valid),
    .avst_source_data          (avst_source_data),
    .avst_source_channel       (avst_source_channel),
    .avst_source_startofpacket (avst_source_startofpacket),
    .avst_source_endofpacket   (avst_source_endofpacket),
    .avst_source_ready         (avst_source_ready),
    .ovf_sticky                (ovf_sticky),
    .drop_cnt                  (drop_cnt)
  );

  always #5 clk_dsp = ~clk_dsp;

  always @(negedge clk_dsp) begin
    if (!rst_dsp && avst_source_valid && avst_source_ready) begin
      cap_data.push_back(avst_source_data);
      cap_chn.push_back(avst_source_channel);
      cap_sop.push_back(avst_source_startofpacket);
      cap_eop.push_back(avst_source_endofpacket);
      $display("beat chn=%0d sop=%0b eop=%0b data=%032h", avst_source_channel,
               avst_source_startofpacket, avst_source_endofpacket, avst_source_data);
    end
  end

  task automatic drive(input logic dv, input logic [4:0] c, input logic [31:0] d, input logic s);
    din_dv  = dv;
    din_chn = c;
    din_dq  = d;
    sync_in = s;
    @(posedge clk_dsp);
    #1;
    din_dv  = 1'b0;
    sync_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_dsp);
      #1;
    end
  endtask

  task automatic apply_reset;
    rst_dsp = 1'b1;
    idle(2);
    rst_dsp = 1'b0;
    idle(1);
  endtask

  task automatic clear_cap;
    cap_data.delete();
    cap_chn.delete();
    cap_sop.delete();
    cap_eop.delete();
  endtask

  function automatic logic [127:0] mk4(input logic [31:0] a);
    return {a, a + 32'd1, a + 32'd2, a + 32'd3};
  endfunction

  task automatic test_reset;
    #1 rst_dsp = 1'b1;
    idle(3);
    checks++;
    if (avst_source_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%0b want=0", avst_source_valid);
    end
    checks++;
    if (avst_source_data !== 128'd0) begin
      failures++; $display("FAIL reset_data got=%032h want=0", avst_source_data);
    end
    checks++;
    if (avst_source_channel !== 16'd0) begin
      failures++; $display("FAIL reset_channel got=%0d want=0", avst_source_channel);
    end
    checks++;
    if ({avst_source_startofpacket, avst_source_endofpacket} !== 2'b00) begin
      failures++; $display("FAIL reset_sop_eop got=%b%b want=00", avst_source_startofpacket, avst_source_endofpacket);
    end
    checks++;
    if (ovf_sticky !== 1'b0) begin
      failures++; $display("FAIL reset_ovf got=%0b want=0", ovf_sticky);
    end
    checks++;
    if (drop_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_drop_cnt got=%0d want=0", drop_cnt);
    end
    rst_dsp = 1'b0;
    idle(2);
    checks++;
    if (avst_source_valid !== 1'b0) begin
      failures++; $display("FAIL idle_valid got=%0b want=0", avst_source_valid);
    end
  endtask

  task automatic test_single_packet;
    apply_reset();
    clear_cap();
    avst_source_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 5'd0, 32'(i), 1'b0);
    checks++;
    if (avst_source_valid !== 1'b0) begin
      failures++; $display("FAIL sp_valid_early got=%0b want=0", avst_source_valid);
    end
    drive(1'b1, 5'd0, 32'd4, 1'b0);
    checks++;
    if (avst_source_valid !== 1'b1 || avst_source_data !== mk4(32'd0) || avst_source_startofpacket !== 1'b1) begin
      failures++; $display("FAIL sp_latency got v=%0b d=%032h sop=%0b want v=1 d=%032h sop=1",
                           avst_source_valid, avst_source_data, avst_source_startofpacket, mk4(32'd0));
    end
    for (int i = 5; i < 64; i++) drive(1'b1, 5'd0, 32'(i), 1'b0);
    idle(5);
    checks++;
    if (cap_data.size() != 16) begin
      failures++; $display("FAIL sp_beat_count got=%0d want=16", cap_data.size());
    end
    for (int k = 0; k < cap_data.size() && k < 16; k++) begin
      checks++;
      if (cap_data[k] !== mk4(32'(4 * k)) || cap_sop[k] !== (k == 0) || cap_eop[k] !== (k == 15) || cap_chn[k] !== 16'd0) begin
        failures++; $display("FAIL sp_beat%0d got d=%032h sop=%0b eop=%0b chn=%0d want d=%032h sop=%0b eop=%0b chn=0",
                             k, cap_data[k], cap_sop[k], cap_eop[k], cap_chn[k], mk4(32'(4 * k)), k == 0, k == 15);
      end
    end
  endtask

  task automatic test_interleave;
    int kc [24];
    int c;
    logic [127:0] exp_d;
    apply_reset();
    clear_cap();
    avst_source_ready = 1'b1;
    for (int i = 0; i < 24; i++) kc[i] = 0;
    for (int s = 0; s < 64; s++)
      for (int ch = 0; ch < 24; ch++) drive(1'b1, 5'(ch), {16'(ch), 16'(s)}, 1'b0);
    idle(10);
    checks++;
    if (cap_data.size() != 384) begin
      failures++; $display("FAIL il_beat_count got=%0d want=384", cap_data.size());
    end
    for (int j = 0; j < cap_data.size(); j++) begin
      c = int'(cap_chn[j]);
      checks++;
      if (c >= 24) begin
        failures++; $display("FAIL il_chn beat%0d got=%0d want<24", j, c);
      end else begin
        exp_d = mk4({16'(c), 16'(4 * kc[c])});
        if (cap_data[j] !== exp_d || cap_sop[j] !== (kc[c] % 16 == 0) || cap_eop[j] !== (kc[c] % 16 == 15)) begin
          failures++; $display("FAIL il_beat chn=%0d k=%0d got d=%032h sop=%0b eop=%0b want d=%032h",
                               c, kc[c], cap_data[j], cap_sop[j], cap_eop[j], exp_d);
        end
        kc[c]++;
      end
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    int kc [24];
    int c;
    logic held;
    logic [127:0] pd;
    logic [127:0] exp_d;
    apply_reset();
    clear_cap();
    cyc = 0;
    for (int i = 0; i < 24; i++) kc[i] = 0;
    for (int s = 0; s < 32; s++) begin
      for (int ch = 0; ch < 24; ch++) begin
        avst_source_ready = (cyc % 4 == 0);
        held = avst_source_valid && !avst_source_ready;
        pd   = avst_source_data;
        drive(1'b1, 5'(ch), {16'(ch), 16'(s)}, 1'b0);
        cyc++;
        if (held) begin
          checks++;
          if (avst_source_valid !== 1'b1 || avst_source_data !== pd) begin
            failures++; $display("FAIL bp_stable cyc=%0d got v=%0b d=%032h want v=1 d=%032h",
                                 cyc, avst_source_valid, avst_source_data, pd);
          end
        end
      end
    end
    avst_source_ready = 1'b1;
    idle(20);
    checks++;
    if (ovf_sticky !== 1'b0) begin
      failures++; $display("FAIL bp_ovf got=%0b want=0", ovf_sticky);
    end
    checks++;
    if (cap_data.size() != 192) begin
      failures++; $display("FAIL bp_beat_count got=%0d want=192", cap_data.size());
    end
    for (int j = 0; j < cap_data.size(); j++) begin
      c = int'(cap_chn[j]);
      checks++;
      if (c >= 24) begin
        failures++; $display("FAIL bp_chn beat%0d got=%0d want<24", j, c);
      end else begin
        exp_d = mk4({16'(c), 16'(4 * kc[c])});
        if (cap_data[j] !== exp_d || cap_sop[j] !== (kc[c] == 0) || cap_eop[j] !== 1'b0) begin
          failures++; $display("FAIL bp_beat chn=%0d k=%0d got d=%032h sop=%0b eop=%0b want d=%032h",
                               c, kc[c], cap_data[j], cap_sop[j], cap_eop[j], exp_d);
        end
        kc[c]++;
      end
    end
  endtask

  task automatic test_overflow;
    logic [15:0] exp_drops;
    int b;
`ifdef PRACH_FRAMER_STATS_EN
    exp_drops = 16'd11;
`else
    exp_drops = 16'd0;
`endif
    apply_reset();
    clear_cap();
    avst_source_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 5'd0, 32'(i), 1'b0);
      if (i == 258) begin
        checks++;
        if (ovf_sticky !== 1'b0) begin
          failures++; $display("FAIL ovf_at_64 got=%0b want=0", ovf_sticky);
        end
      end
    end
    idle(3);
    checks++;
    if (ovf_sticky !== 1'b1) begin
      failures++; $display("FAIL ovf_sticky got=%0b want=1", ovf_sticky);
    end
    checks++;
    if (drop_cnt !== exp_drops) begin
      failures++; $display("FAIL ovf_drop_cnt got=%0d want=%0d", drop_cnt, exp_drops);
    end
    avst_source_ready = 1'b1;
    idle(70);
    checks++;
    if (cap_data.size() != 64) begin
      failures++; $display("FAIL ovf_drain_count got=%0d want=64", cap_data.size());
    end
    for (int j = 0; j < cap_data.size() && j < 64; j++) begin
      checks++;
      if (cap_data[j] !== mk4(32'(4 * j)) || cap_sop[j] !== (j % 16 == 0) || cap_eop[j] !== (j % 16 == 15)) begin
        failures++; $display("FAIL ovf_drain beat%0d got d=%032h sop=%0b eop=%0b want d=%032h",
                             j, cap_data[j], cap_sop[j], cap_eop[j], mk4(32'(4 * j)));
      end
    end
    clear_cap();
    for (int i = 300; i < 384; i++) drive(1'b1, 5'd0, 32'(i), 1'b0);
    idle(5);
    checks++;
    if (cap_data.size() != 21) begin
      failures++; $display("FAIL ovf_resume_count got=%0d want=21", cap_data.size());
    end
    for (int j = 0; j < cap_data.size() && j < 21; j++) begin
      b = 75 + j;
      checks++;
      if (cap_data[j] !== mk4(32'(4 * b)) || cap_sop[j] !== (b % 16 == 0) || cap_eop[j] !== (b % 16 == 15)) begin
        failures++; $display("FAIL ovf_resume beat%0d got d=%032h sop=%0b eop=%0b want d=%032h sop=%0b eop=%0b",
                             b, cap_data[j], cap_sop[j], cap_eop[j], mk4(32'(4 * b)), b % 16 == 0, b % 16 == 15);
      end
    end
  endtask

  task automatic test_sync;
    logic [127:0] exp_aa;
    apply_reset();
    clear_cap();
    avst_source_ready = 1'b1;
    exp_aa = {32'hAA, 32'hBB, 32'hCC, 32'hDD};
    for (int i = 0; i < 4; i++) drive(1'b1, 5'd5, 32'(1 + i), 1'b0);
    drive(1'b1, 5'd5, 32'h11, 1'b0);
    drive(1'b1, 5'd5, 32'h22, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 5'd7, 32'(8'h71 + i), 1'b0);
    drive(1'b1, 5'd5, 32'hAA, 1'b1);
    drive(1'b1, 5'd5, 32'hBB, 1'b0);
    drive(1'b1, 5'd5, 32'hCC, 1'b0);
    drive(1'b1, 5'd5, 32'hDD, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 5'd7, 32'(8'h80 + i), 1'b0);
    idle(5);
    checks++;
    if (cap_data.size() != 3) begin
      failures++; $display("FAIL sync_count got=%0d want=3", cap_data.size());
    end
    if (cap_data.size() >= 3) begin
      checks++;
      if (cap_data[0] !== mk4(32'd1) || cap_sop[0] !== 1'b1) begin
        failures++; $display("FAIL sync_pre_beat got d=%032h sop=%0b want d=%032h sop=1", cap_data[0], cap_sop[0], mk4(32'd1));
      end
      checks++;
      if (cap_data[1] !== exp_aa || cap_sop[1] !== 1'b1 || cap_eop[1] !== 1'b0 || cap_chn[1] !== 16'd5) begin
        failures++; $display("FAIL sync_chn5 got d=%032h sop=%0b eop=%0b chn=%0d want d=%032h sop=1 eop=0 chn=5",
                             cap_data[1], cap_sop[1], cap_eop[1], cap_chn[1], exp_aa);
      end
      checks++;
      if (cap_data[2] !== mk4(32'h80) || cap_sop[2] !== 1'b1 || cap_chn[2] !== 16'd7) begin
        failures++; $display("FAIL sync_chn7 got d=%032h sop=%0b chn=%0d want d=%032h sop=1 chn=7",
                             cap_data[2], cap_sop[2], cap_chn[2], mk4(32'h80));
      end
    end
  endtask

  task automatic test_async_reset;
    apply_reset();
    clear_cap();
    avst_source_ready = 1'b0;
    for (int i = 0; i < 42; i++) drive(1'b1, 5'd3, 32'(i), 1'b0);
    idle(3);
    checks++;
    if (avst_source_valid !== 1'b1) begin
      failures++; $display("FAIL ar_queued got=%0b want=1", avst_source_valid);
    end
    #2 rst_dsp = 1'b1;
    #1;
    checks++;
    if (avst_source_valid !== 1'b0) begin
      failures++; $display("FAIL ar_async_valid got=%0b want=0", avst_source_valid);
    end
    idle(2);
    rst_dsp = 1'b0;
    avst_source_ready = 1'b1;
    idle(10);
    checks++;
    if (cap_data.size() != 0) begin
      failures++; $display("FAIL ar_no_emit got=%0d want=0", cap_data.size());
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 5'd3, 32'(8'hF0 + i), 1'b0);
    idle(4);
    checks++;
    if (cap_data.size() != 1) begin
      failures++; $display("FAIL ar_post_count got=%0d want=1", cap_data.size());
    end
    if (cap_data.size() >= 1) begin
      checks++;
      if (cap_data[0] !== mk4(32'hF0) || cap_sop[0] !== 1'b1 || cap_chn[0] !== 16'd3) begin
        failures++; $display("FAIL ar_post_beat got d=%032h sop=%0b chn=%0d want d=%032h sop=1 chn=3",
                             cap_data[0], cap_sop[0], cap_chn[0], mk4(32'hF0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_interleave();
    test_backpressure();
    test_overflow();
    test_sync();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prach_pkt_framer.md
# prach_pkt_framer

Packetizing output stage of `prach_top`, downstream of the DDC (`u_ddc`). It consumes time-multiplexed decimated PRACH IQ samples (one 32-bit sample per cycle, tagged with an antenna/carrier channel index). It packs four consecutive samples of the same channel into one 128-bit beat. Beats are buffered in a FIFO and emitted as fixed-length Avalon-ST packets with SOP/EOP, channel and `ready` backpressure toward the xRAN packet builder.

## Interface
- `NumChn`, 24: logical channels (ant*3+cc), valid index 0..NumChn-1
- `PktBeats`, 16: beats per packet per channel (≥2)
- `FifoDepth`, 64: output FIFO depth in beats (power of 2)
- `clk_dsp`  in  1  sole clock, 491.52 MHz
- `rst_dsp`  in  1  asynchronous, active-high reset
- `sync_in`  in  1  one-cycle pulse; realigns all channels
- `din_dv`  in  1  input sample valid
- `din_chn`  in  5  channel of input sample
- `din_dq`  in  32  {Q[15:0], I[15:0]} sample
- `avst_source_valid`  out  1  beat valid
- `avst_source_data`  out  128  four samples, sample 0 in [127:96]
- `avst_source_channel`  out  16  channel index, zero-extended
- `avst_source_startofpacket`  out  1  first beat of packet
- `avst_source_endofpacket`  out  1  last beat of packet
- `avst_source_ready`  in  1  sink ready
- `ovf_sticky`  out  1  beat dropped since reset
- `drop_cnt`  out  16  dropped-beat count (only with `PRACH_FRAMER_STATS_EN`)

## Operation
- Per-channel state, held in a NumChn-entry array: 96-bit partial word, 2-bit sample index `sidx`, beat counter `bidx` (0..PktBeats-1).
- Input with `din_dv=1` and `din_chn<NumChn`: sample is written to slot `sidx`. The array is read and written in the same cycle, and a same-channel back-to-back sample must see the updated state through forwarding.
- `din_chn≥NumChn`: sample ignored; no state change.
- When `sidx` reaches 3, the full beat {slot0, slot1, slot2, din_dq} forms, `sidx` returns to 0, and a beat is pushed.
  - SOP = (`bidx==0`), EOP = (`bidx==PktBeats-1`).
  - `bidx` increments, wrapping from PktBeats-1 to 0.
- FIFO entry: {data, chn, sop, eop}.
  - A push when the FIFO is full drops the beat and sets `ovf_sticky`.
  - The channel's `bidx` still advances on a drop, so following packets stay aligned. The affected packet is delivered short or without SOP/EOP; the sink discards it.
- `sync_in=1`: all `sidx` and `bidx` clear to 0 and partial words are discarded.
  - A sample arriving in the sync cycle is treated as sample 0, beat 0 of its channel.
  - FIFO content is not flushed.
- Output follows Avalon-ST: the beat is transferred when valid&ready.
  - valid stays high and data stays stable until transfer.
  - ready is honoured with zero ready-latency.
  - Simultaneous push and pop at full is permitted and is not an overflow.

## Timing
- Input to FIFO write: 1 cycle after the 4th sample of a beat.
- FIFO write to `avst_source_valid`: 1 cycle (registered show-ahead output). Minimum total latency: 4th sample at cycle n gives valid at n+2.
- Throughput: 1 sample/cycle in, 1 beat/cycle out. The output needs ready duty ≥25% at full input rate.
- Reset values:
  - All outputs 0, `avst_source_channel`=0.
  - FIFO empty, all `sidx`/`bidx`=0.
  - `ovf_sticky`=0, `drop_cnt`=0.
- Reset mid-packet: everything returns to reset state immediately (asynchronous). Partial packets are lost, and the next beat after release carries SOP.

## Configuration
- `PRACH_FRAMER_STATS_EN` defined: `drop_cnt` increments on each dropped beat and saturates at 16'hFFFF.
- `PRACH_FRAMER_STATS_EN` undefined: the counter logic is removed and `drop_cnt` is tied to 0. `ovf_sticky` is always present.

## Test plan
- Single packet: ready=1, chn 0 fed with 64 samples 0x00000000..0x0000003F (only chn 0 valid). Required: 16 beats; beat 0 = {0,1,2,3} with SOP=1; beat 15 = {3C..3F} with EOP=1; channel=0; valid 2 cycles after sample 3.
- Interleaving: round-robin chn 0..23, sample value {chn, seq}. Required: per-channel beats contain only their own samples in order, with SOP every 16 beats per channel.
- Backpressure: ready toggled 1 cycle high / 3 low at full input rate. Required: no drops, data stable while valid&!ready, and `ovf_sticky`=0.
- Overflow: ready=0 for 300 cycles at full input rate. Required: after 64 beats, pushes are dropped and `ovf_sticky`=1. With the macro, `drop_cnt` equals the beats formed minus 64. Output resumes correctly once ready=1.
- Sync mid-beat: chn 5 gets 2 samples, then `sync_in` together with sample 0xAA. Required: the next chn 5 beat starts with 0xAA and has SOP=1.
- Async reset with 10 beats queued: `rst_dsp` is pulsed. Required: valid drops immediately, nothing queued is emitted, and the first post-reset beat carries SOP.
